// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped bank of NUM_GPIO bidirectional pins with
// per-pin direction, set/clear output access, synchronised pad sampling
// and rising/falling edge interrupts collected into a W1C PENDING register.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst          - asynchronous, active-high reset
//   en           - bank select from the address decoder
//   write_enable - [0] word, [1] half, [2] byte; any nonzero bit writes
//                  the full register
//   addr         - byte address, only addr[4:2] selects a register
//   data_in      - write data, bits [NUM_GPIO-1:0] used
//   data_out     - combinational read data, high-Z while en=0
//   gpio         - pads; driven from OUT where DIR=1, high-Z otherwise
//   irq          - level interrupt, OR of PENDING
module gpio_bank #(
  parameter int unsigned NUM_GPIO    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          write_enable,
  input  logic [31:0]         addr,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  inout  wire  [NUM_GPIO-1:0] gpio,
  output logic                irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_SET     = 3'd2,
    REG_CLR     = 3'd3,
    REG_RISE_EN = 3'd4,
    REG_FALL_EN = 3'd5,
    REG_PENDING = 3'd6,
    REG_RSVD    = 3'd7
  } reg_sel_e;

  reg_sel_e sel;
  logic     bus_wr;
  logic [NUM_GPIO-1:0] wdata;

  logic [NUM_GPIO-1:0] out_q, dir_q, rise_en_q, fall_en_q, pend_q;
  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q;
  logic [NUM_GPIO-1:0] prev_q;
  logic [NUM_GPIO-1:0] sync_val, rise, fall, pend_set, pend_clr;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign sel    = reg_sel_e'(addr[4:2]);
  assign bus_wr = en && (write_enable != '0);
  assign wdata  = data_in[NUM_GPIO-1:0];

  // Address bits outside [4:2] and data bits above NUM_GPIO are don't-care.
  assign unused_bits = ^{addr[31:5], addr[1:0], data_in};

  // Pad synchroniser followed by a single history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise     = sync_val & ~prev_q;
  assign fall     = ~sync_val & prev_q;
  assign pend_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign pend_clr = (bus_wr && sel == REG_PENDING) ? wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      // Set is OR-ed in after the W1C mask so a coinciding edge wins.
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      if (bus_wr) begin
        case (sel)
          REG_DATA:    out_q     <= (out_q & ~dir_q) | (wdata & dir_q);
          REG_DIR:     dir_q     <= wdata;
          REG_SET:     out_q     <= out_q | wdata;
          REG_CLR:     out_q     <= out_q & ~wdata;
          REG_RISE_EN: rise_en_q <= wdata;
          REG_FALL_EN: fall_en_q <= wdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_DATA:    rdata[NUM_GPIO-1:0] = (out_q & dir_q) | (sync_val & ~dir_q);
      REG_DIR:     rdata[NUM_GPIO-1:0] = dir_q;
      REG_RISE_EN: rdata[NUM_GPIO-1:0] = rise_en_q;
      REG_FALL_EN: rdata[NUM_GPIO-1:0] = fall_en_q;
      REG_PENDING: rdata[NUM_GPIO-1:0] = pend_q;
      default:     rdata = '0;
    endcase
  end

  assign data_out = en ? rdata : 'z;
  assign irq      = |pend_q;

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pad
    assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed scenarios followed by randomized bus and pad
// traffic, checked through a scoreboard queue against a cycle-level model.
module tb_gpio_bank;
  localparam int N  = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  write_enable = '0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  wire  [31:0] data_out_w;
  wire  [N-1:0] gpio_w;
  logic        irq;

  // Bench-side pad drivers; undriven pads float high through the pullup.
  logic [N-1:0] tb_oe  = '0;
  logic [N-1:0] tb_val = '0;

  pullup (gpio_w);
  pullup (data_out_w);

  for (genvar i = 0; i < N; i++) begin : g_tbpad
    assign gpio_w[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  gpio_bank #(.NUM_GPIO(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .en(en), .write_enable(write_enable),
    .addr(addr), .data_in(data_in), .data_out(data_out_w),
    .gpio(gpio_w), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          kind;   // 0 data_out, 1 pads, 2 irq
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic chk_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_valid) begin
      while (sbq.size() > 0) begin
        chk_t        c;
        logic [31:0] got;
        c = sbq.pop_front();
        case (c.kind)
          0:       got = data_out_w;
          1:       got = {{(32-N){1'b0}}, gpio_w};
          default: got = {31'b0, irq};
        endcase
        total++;
        if (got !== c.exp) begin
          bad++;
          $display("FAIL %s: got=%h required=%h", c.name, got, c.exp);
        end
      end
    end
  end

  task automatic push_chk(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sbq.push_back(c);
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_out, m_dir, m_rise, m_fall, m_pend;
  logic [N-1:0] hist[$];   // last SS+1 pad samples, oldest first

  function automatic logic [N-1:0] pad_now();
    return (m_dir & m_out) | (~m_dir & tb_oe & tb_val) | (~m_dir & ~tb_oe);
  endfunction

  // Synchronised view lags the pads by SS samples; the oldest entry is PREV.
  function automatic logic [31:0] m_read(input int a);
    logic [N-1:0] v;
    case (a)
      0:       v = (m_out & m_dir) | (hist[1] & ~m_dir);
      1:       v = m_dir;
      4:       v = m_rise;
      5:       v = m_fall;
      6:       v = m_pend;
      default: v = '0;
    endcase
    return {{(32-N){1'b0}}, v};
  endfunction

  task automatic model_clear();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    hist.delete();
    for (int i = 0; i < SS + 1; i++) hist.push_back('0);
  endtask

  task automatic idle();
    en = 1'b0;
    write_enable = '0;
    addr = '0;
    data_in = '0;
  endtask

  // One clock cycle: queue irq/pad checks, advance the model across the edge.
  task automatic tick();
    logic [N-1:0] sy, pv, setv, w, pad;
    push_chk(2, {31'b0, |m_pend}, "irq_model");
    push_chk(1, {{(32-N){1'b0}}, pad_now()}, "pads_model");
    chk_valid = 1'b1;
    pad  = pad_now();
    sy   = hist[1];
    pv   = hist[0];
    setv = (sy & ~pv & m_rise) | (~sy & pv & m_fall);
    if (en && write_enable != 3'b000) begin
      w = data_in[N-1:0];
      case (addr[4:2])
        3'd0: m_out = (m_out & ~m_dir) | (w & m_dir);
        3'd1: m_dir = w;
        3'd2: m_out = m_out | w;
        3'd3: m_out = m_out & ~w;
        3'd4: m_rise = w;
        3'd5: m_fall = w;
        3'd6: m_pend = m_pend & ~w;
        default: ;
      endcase
    end
    m_pend = m_pend | setv;
    hist.push_back(pad);
    hist.delete(0);
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic wr(input int a, input logic [N-1:0] d);
    en = 1'b1;
    write_enable = 3'($urandom_range(1, 7));
    addr = $urandom;
    addr[4:2] = 3'(a);
    data_in = $urandom;
    data_in[N-1:0] = d;
    if (a == 1) tb_oe = tb_oe & ~d;   // never fight a pin about to become an output
    tick();
    idle();
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string name);
    en = 1'b1;
    write_enable = '0;
    addr = $urandom;
    addr[4:2] = 3'(a);
    push_chk(0, exp, name);
    tick();
    idle();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle();
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      en = 1'b1;
      addr = $urandom;
      addr[4:2] = 3'(i % 8);
      push_chk(0, 32'h0, "rst_read");
      push_chk(2, 32'h0, "rst_irq");
      push_chk(1, {{(32-N){1'b0}}, pad_now()}, "rst_pads");
      chk_valid = 1'b1;
      @(posedge clk);
      #1;
      chk_valid = 1'b0;
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic random_burst(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          a = int'($urandom_range(0, 7));
          wr(a, N'($urandom));
          if (a == 1) tb_oe = ~m_dir;
        end
        4, 5, 6: begin
          a = int'($urandom_range(0, 7));
          rd(a, m_read(a), "rand_read");
        end
        7, 8: begin
          tb_val = N'($urandom);
          tick();
        end
        default: tick();
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    idle();
    model_clear();
    @(posedge clk);
    #1;

    // Reset with all pads floating high: pads Z, irq low, every read 0.
    tb_oe = '0;
    do_reset(8);
    push_chk(1, 32'hFF, "rst_release_pads_z");
    repeat (SS + 3) tick();
    rd(6, 32'h0, "pend_after_rst_release");

    // Output path.
    wr(1, 8'hFF);
    wr(0, 8'hA5);
    push_chk(1, 32'hA5, "out_a5");
    wr(2, 8'h0A);
    push_chk(1, 32'hAF, "set_af");
    wr(3, 8'h81);
    push_chk(1, 32'h2E, "clr_2e");
    rd(0, 32'h2E, "data_rd_2e");

    // Masked DATA write with external pads on the upper nibble.
    wr(1, 8'h0F);
    tb_oe  = 8'hF0;
    tb_val = 8'h30;
    wr(0, 8'hFF);
    push_chk(1, 32'h3F, "masked_pads");
    rd(0, 32'h2F, "data_rd_before_sync");
    rd(0, 32'h3F, "data_rd_masked");

    // Rising-edge interrupt on pad0, exact latency.
    wr(3, 8'h01);
    wr(1, 8'h00);
    tb_oe  = 8'hFF;
    tb_val = 8'h30;
    repeat (SS + 1) tick();
    wr(4, 8'h01);
    repeat (SS + 1) tick();
    rd(6, 32'h0, "pend_pre_rise");
    tb_val[0] = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      tick();
      push_chk(2, (k == SS + 1) ? 32'h1 : 32'h0, "rise_irq_latency");
    end
    rd(6, 32'h1, "pend_rise");
    tb_val[0] = 1'b0;
    for (int k = 0; k < SS + 2; k++) begin
      push_chk(2, 32'h1, "irq_hold_no_fall");
      tick();
    end
    rd(6, 32'h1, "pend_no_fall");

    // W1C colliding with a new set on bit0.
    wr(4, 8'h03);
    tb_val[1] = 1'b1;
    repeat (SS + 1) tick();
    rd(6, 32'h3, "pend_03");
    tb_val[0] = 1'b1;
    repeat (SS) tick();
    wr(6, 8'h01);
    rd(6, 32'h3, "w1c_collision");
    wr(6, 8'h03);
    push_chk(2, 32'h0, "irq_cleared");
    rd(6, 32'h0, "pend_cleared");

    // Bus isolation and reserved/strobe addresses.
    en = 1'b0;
    write_enable = 3'b001;
    addr = 32'h0000_0004;
    data_in = 32'hFF;
    push_chk(0, 32'hFFFF_FFFF, "data_out_z");
    tick();
    idle();
    rd(1, 32'h0, "dir_unchanged_en0");
    wr(7, 8'hFF);
    rd(7, 32'h0, "rsvd_read");
    rd(2, 32'h0, "set_read");
    rd(3, 32'h0, "clr_read");
    rd(1, 32'h0, "dir_after_rsvd");
    rd(4, 32'h3, "rise_en_after_rsvd");
    rd(5, 32'h0, "fall_en_after_rsvd");

    // Randomized traffic.
    tb_oe = ~m_dir;
    random_burst(400);

    // Reset landing in the middle of a write cycle.
    en = 1'b1;
    write_enable = 3'b111;
    addr = 32'h0000_0004;
    data_in = 32'hFF;
    #3;
    do_reset(4);
    tb_oe = '1;
    rd(1, 32'h0, "dir_after_abort");
    rd(6, 32'h0, "pend_after_abort");
    random_burst(150);

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
